// File: rtl/lockpick_host_driver_if.sv
// rtl/lockpick_host_driver_if.sv - host command, game byte bus and response signals of lockpick_host_driver
// LOCKPICK_DRV_CHECK_EN adds rsp_proto_err to the bundle.
interface lockpick_host_driver_if;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [255:0] cmd_key_a;
   logic [255:0] cmd_key_b;
   logic         game_start;
   logic         game_in_en;
   logic [7:0]   game_in_data;
   logic         game_out_valid;
   logic [7:0]   game_out_data;
   logic [1:0]   game_status;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [255:0] rsp_msg;
   logic [1:0]   rsp_status;
   logic         rsp_timeout;
   logic [1:0]   attempt_cnt;
   logic         session_open;
`ifdef LOCKPICK_DRV_CHECK_EN
   logic         rsp_proto_err;
`endif

   modport master (
      input  cmd_valid, cmd_key_a, cmd_key_b,
      input  game_out_valid, game_out_data, game_status, rsp_ready,
      output cmd_ready, game_start, game_in_en, game_in_data,
      output rsp_valid, rsp_msg, rsp_status, rsp_timeout, attempt_cnt, session_open
`ifdef LOCKPICK_DRV_CHECK_EN
      , output rsp_proto_err
`endif
   );

   modport slave (
      output cmd_valid, cmd_key_a, cmd_key_b,
      output game_out_valid, game_out_data, game_status, rsp_ready,
      input  cmd_ready, game_start, game_in_en, game_in_data,
      input  rsp_valid, rsp_msg, rsp_status, rsp_timeout, attempt_cnt, session_open
`ifdef LOCKPICK_DRV_CHECK_EN
      , input rsp_proto_err
`endif
   );
endinterface

// File: rtl/lockpick_host_driver.sv
// rtl/lockpick_host_driver.sv - lockpick player side: sends a key pair, collects the 32-byte result
// LOCKPICK_DRV_CHECK_EN enables the result-pattern checker driving rsp_proto_err.
module lockpick_host_driver #(
   parameter int PACE    = 0,
   parameter int TIMEOUT = 1023
) (
   input  logic                   clk,
   input  logic                   rst_n,
   lockpick_host_driver_if.master bus
);
   localparam int PW = (PACE > 0) ? $clog2(PACE + 1) : 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [PW-1:0] PACE_L = PW'(PACE);
   localparam logic [TW-1:0] TMO_L  = TW'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_SEND_A, S_SEND_B, S_WAIT, S_RECV, S_RESP
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [255:0]  r_key_a, r_key_b, r_msg;
   logic [4:0]    r_byte_idx;
   logic [PW-1:0] r_pace_cnt;
   logic [TW-1:0] r_tmo_cnt;
   logic [1:0]    r_status, r_attempt;
   logic          r_timeout, r_session;

   logic          w_slot_end, w_idx_last, w_tmo_hit, w_in_en;
   logic [7:0]    w_key_byte, w_idx_bit;
   logic [TW-1:0] w_tmo_inc;

   assign w_idx_bit  = {r_byte_idx, 3'b000};
   assign w_idx_last = (r_byte_idx == 5'd31);
   assign w_slot_end = (r_pace_cnt == PACE_L);
   assign w_tmo_inc  = r_tmo_cnt + TW'(1);
   assign w_tmo_hit  = (w_tmo_inc == TMO_L);

`ifdef LOCKPICK_DRV_CHECK_EN
   logic         r_proto_err, w_proto_err;
   logic [31:0]  w_pat;
   logic [255:0] w_msg_full;

   // Only meaningful on the 32nd beat, when the incoming byte completes the message.
   always_comb begin
      w_msg_full = {bus.game_out_data, r_msg[247:0]};
      case (bus.game_status)
         2'b10:   w_pat = 32'hFACEFACE;
         2'b01:   w_pat = 32'hBAD0BAD0;
         2'b11:   w_pat = 32'hDEADDEAD;
         default: w_pat = 32'h0;
      endcase
      w_proto_err = (bus.game_status == 2'b00) || (w_msg_full != {8{w_pat}});
   end

   assign bus.rsp_proto_err = r_proto_err;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_en     = 1'b0;
      w_key_byte  = 8'd0;
      case (r_state)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               w_state_nxt = r_session ? S_SEND_A : S_START;
            end
         end
         S_START: w_state_nxt = S_SEND_A;
         S_SEND_A, S_SEND_B: begin
            w_in_en = (r_pace_cnt == '0);
            if (w_in_en) begin
               w_key_byte = (r_state == S_SEND_B) ? r_key_b[w_idx_bit +: 8] : r_key_a[w_idx_bit +: 8];
            end
            if (w_slot_end && w_idx_last) begin
               w_state_nxt = (r_state == S_SEND_A) ? S_SEND_B : S_WAIT;
            end
         end
         S_WAIT, S_RECV: begin
            if (bus.game_out_valid) begin
               w_state_nxt = w_idx_last ? S_RESP : S_RECV;
            end else if (w_tmo_hit) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_a     <= '0;
         r_key_b     <= '0;
         r_msg       <= '0;
         r_byte_idx  <= '0;
         r_pace_cnt  <= '0;
         r_tmo_cnt   <= '0;
         r_status    <= 2'b00;
         r_attempt   <= 2'd0;
         r_timeout   <= 1'b0;
         r_session   <= 1'b0;
`ifdef LOCKPICK_DRV_CHECK_EN
         r_proto_err <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  r_key_a    <= bus.cmd_key_a;
                  r_key_b    <= bus.cmd_key_b;
                  r_byte_idx <= '0;
                  r_pace_cnt <= '0;
               end
            end
            S_SEND_A, S_SEND_B: begin
               r_tmo_cnt <= '0;
               if (w_slot_end) begin
                  r_pace_cnt <= '0;
                  r_byte_idx <= r_byte_idx + 5'd1;
               end else begin
                  r_pace_cnt <= r_pace_cnt + PW'(1);
               end
            end
            S_WAIT, S_RECV: begin
               if (bus.game_out_valid) begin
                  r_msg[w_idx_bit +: 8] <= bus.game_out_data;
                  r_byte_idx            <= r_byte_idx + 5'd1;
                  r_tmo_cnt             <= '0;
                  if (w_idx_last) begin
                     r_status  <= bus.game_status;
                     r_timeout <= 1'b0;
`ifdef LOCKPICK_DRV_CHECK_EN
                     r_proto_err <= w_proto_err;
`endif
                     case (bus.game_status)
                        2'b01: begin
                           r_session <= 1'b1;
                           if (r_attempt != 2'd2) begin
                              r_attempt <= r_attempt + 2'd1;
                           end
                        end
                        2'b00: r_session <= 1'b0;
                        default: begin
                           r_session <= 1'b0;
                           r_attempt <= 2'd0;
                        end
                     endcase
                  end
               end else if (w_tmo_hit) begin
                  // Game went silent: the session state is unknown, so force a fresh start.
                  r_status   <= 2'b00;
                  r_timeout  <= 1'b1;
                  r_session  <= 1'b0;
                  r_attempt  <= 2'd0;
                  r_byte_idx <= '0;
`ifdef LOCKPICK_DRV_CHECK_EN
                  r_proto_err <= 1'b0;
`endif
               end else begin
                  r_tmo_cnt <= w_tmo_inc;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.cmd_ready    = (r_state == S_IDLE);
   assign bus.game_start   = (r_state == S_START);
   assign bus.game_in_en   = w_in_en;
   assign bus.game_in_data = w_key_byte;
   assign bus.rsp_valid    = (r_state == S_RESP);
   assign bus.rsp_msg      = r_msg;
   assign bus.rsp_status   = r_status;
   assign bus.rsp_timeout  = r_timeout;
   assign bus.attempt_cnt  = r_attempt;
   assign bus.session_open = r_session;
endmodule
